// File: rtl/pre_mac_tx_arbiter.sv
// Packet-granular round-robin arbiter that merges NUM_PORTS AXI-Stream sources onto one MAC TX stream.
// Define PRE_MAC_ARB_PKT_CNT_EN to add per-port accepted-packet counters on pkt_cnt.
module pre_mac_tx_arbiter #(
  parameter int AXIS_BUS_WIDTH   = 64,
  parameter int AXIS_ID_WIDTH    = 2,
  parameter int ROUTE_MASK_WIDTH = 16
) (
  input  logic                                             aclk,
  input  logic                                             areset,
  input  logic [(2**AXIS_ID_WIDTH)*AXIS_BUS_WIDTH-1:0]     s_axis_tdata,
  input  logic [(2**AXIS_ID_WIDTH)*(AXIS_BUS_WIDTH/8)-1:0] s_axis_tkeep,
  input  logic [(2**AXIS_ID_WIDTH)-1:0]                    s_axis_tlast,
  input  logic [(2**AXIS_ID_WIDTH)-1:0]                    s_axis_tvalid,
  output logic [(2**AXIS_ID_WIDTH)-1:0]                    s_axis_tready,
  input  logic [(2**AXIS_ID_WIDTH)*ROUTE_MASK_WIDTH-1:0]   route_mask_cfg,
  output logic [AXIS_BUS_WIDTH-1:0]                        m_axis_tdata,
  output logic [AXIS_BUS_WIDTH/8-1:0]                      m_axis_tkeep,
  output logic [ROUTE_MASK_WIDTH-1:0]                      m_axis_tuser,
  output logic [AXIS_ID_WIDTH-1:0]                         m_axis_tid,
  output logic                                             m_axis_tlast,
  output logic                                             m_axis_tvalid,
  input  logic                                             m_axis_tready,
`ifdef PRE_MAC_ARB_PKT_CNT_EN
  output logic [(2**AXIS_ID_WIDTH)*32-1:0]                 pkt_cnt,
`endif
  output logic                                             grant_active
);

  localparam int NUM_PORTS = 2**AXIS_ID_WIDTH;
  localparam int KW        = AXIS_BUS_WIDTH / 8;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                      r_state, w_state_next;
  logic [AXIS_ID_WIDTH-1:0]    r_rr_ptr, r_grant, w_sel, w_idx;
  logic [ROUTE_MASK_WIDTH-1:0] r_mask;
  logic                        w_any_valid, w_can_load, w_accept, w_in_valid, w_in_last;

  logic [AXIS_BUS_WIDTH-1:0]   r_tdata;
  logic [KW-1:0]               r_tkeep;
  logic [ROUTE_MASK_WIDTH-1:0] r_tuser;
  logic [AXIS_ID_WIDTH-1:0]    r_tid;
  logic                        r_tlast, r_tvalid;

  // First valid port after the last winner; offset NUM_PORTS wraps back onto rr_ptr itself.
  always_comb begin
    w_sel       = '0;
    w_idx       = '0;
    w_any_valid = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_idx = r_rr_ptr + AXIS_ID_WIDTH'(i);
      if (!w_any_valid && s_axis_tvalid[w_idx]) begin
        w_any_valid = 1'b1;
        w_sel       = w_idx;
      end
    end
  end

  assign w_can_load = !r_tvalid || m_axis_tready;
  assign w_in_valid = s_axis_tvalid[r_grant];
  assign w_in_last  = s_axis_tlast[r_grant];
  assign w_accept   = (r_state == StLocked) && w_in_valid && w_can_load;

  always_comb begin
    s_axis_tready = '0;
    if (r_state == StLocked) s_axis_tready[r_grant] = w_can_load;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (w_any_valid) w_state_next = StLocked;
      StLocked: if (w_accept && w_in_last) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= StIdle;
      r_rr_ptr <= AXIS_ID_WIDTH'(NUM_PORTS - 1);
      r_grant  <= '0;
      r_mask   <= '0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tuser  <= '0;
      r_tid    <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && w_any_valid) begin
        r_grant  <= w_sel;
        r_rr_ptr <= w_sel;
        r_mask   <= route_mask_cfg[w_sel*ROUTE_MASK_WIDTH +: ROUTE_MASK_WIDTH];
      end
      if (w_accept) begin
        r_tdata  <= s_axis_tdata[r_grant*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
        r_tkeep  <= s_axis_tkeep[r_grant*KW +: KW];
        r_tlast  <= w_in_last;
        r_tid    <= r_grant;
        r_tuser  <= r_mask;
        r_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tid    = r_tid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;
  assign grant_active  = (r_state == StLocked);

`ifdef PRE_MAC_ARB_PKT_CNT_EN
  logic [NUM_PORTS-1:0][31:0] r_pkt_cnt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_pkt_cnt <= '0;
    end else if (w_accept && w_in_last) begin
      r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + 32'd1;
    end
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_pre_mac_tx_arbiter.sv
// Self-checking bench for pre_mac_tx_arbiter: per-port packet sources feed a scoreboard of
// expected output beats, compared as they leave the output register.
module tb_pre_mac_tx_arbiter;
  localparam int W   = 64;
  localparam int IDW = 2;
  localparam int N   = 4;
  localparam int RMW = 16;
  localparam int KW  = W / 8;

  typedef struct packed {
    logic [W-1:0]   data;
    logic [KW-1:0]  keep;
    logic [RMW-1:0] user;
    logic [IDW-1:0] id;
    logic           last;
  } exp_t;

  logic           aclk = 1'b0;
  logic           areset;
  logic [N*W-1:0] s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic [N-1:0]   s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [N*RMW-1:0] route_mask_cfg;
  logic [W-1:0]   m_axis_tdata;
  logic [KW-1:0]  m_axis_tkeep;
  logic [RMW-1:0] m_axis_tuser;
  logic [IDW-1:0] m_axis_tid;
  logic           m_axis_tlast, m_axis_tvalid, m_axis_tready, grant_active;
`ifdef PRE_MAC_ARB_PKT_CNT_EN
  logic [N*32-1:0] pkt_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  int          req_pkts[N], done_pkts[N], len[N], beat[N];
  logic [31:0] seq[N];
  logic [N-1:0] pause, acc_pend;
  logic        all_valid;
  logic [RMW-1:0] exp_mask[N];
  exp_t        sb[$];
  int          order_log[64];
  int          order_n = 0;
  int          out_beats = 0;
  logic [RMW-1:0] last_out_user;

  always #5 aclk = ~aclk;

  for (genvar p = 0; p < N; p++) begin : g_src
    assign s_axis_tvalid[p]          = all_valid || ((req_pkts[p] != done_pkts[p]) && !pause[p]);
    assign s_axis_tdata[p*W +: W]    = {32'(p), seq[p]};
    assign s_axis_tkeep[p*KW +: KW]  = seq[p][7:0] ^ 8'(p * 17);
    assign s_axis_tlast[p]           = (beat[p] == len[p] - 1);
  end

  pre_mac_tx_arbiter #(
    .AXIS_BUS_WIDTH  (W),
    .AXIS_ID_WIDTH   (IDW),
    .ROUTE_MASK_WIDTH(RMW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .route_mask_cfg(route_mask_cfg),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
`ifdef PRE_MAC_ARB_PKT_CNT_EN
    .pkt_cnt       (pkt_cnt),
`endif
    .grant_active  (grant_active)
  );

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  // Advances each source by one beat after the edge on which it was accepted.
  task automatic source_engine();
    forever begin
      @(posedge aclk);
      #1;
      for (int p = 0; p < N; p++) begin
        if (acc_pend[p]) begin
          seq[p] = seq[p] + 32'd1;
          if (beat[p] == len[p] - 1) begin
            beat[p] = 0;
            done_pkts[p]++;
          end else begin
            beat[p]++;
          end
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e, got, held;
    bit   held_valid = 1'b0;
    bit   in_pkt = 1'b0;
    int   cur_port = 0;
    forever begin
      @(negedge aclk);
      got = '{data: m_axis_tdata, keep: m_axis_tkeep, user: m_axis_tuser,
              id: m_axis_tid, last: m_axis_tlast};
      acc_pend = s_axis_tvalid & s_axis_tready;
      if (held_valid) begin
        checks++;
        if (!m_axis_tvalid || got !== held) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b %h required valid=1 %h", m_axis_tvalid, got, held);
        end
      end
      if (m_axis_tvalid && !m_axis_tready) begin
        checks++;
        if (s_axis_tready !== '0) begin
          errors++;
          $display("FAIL tready_while_full: got %b required 0000", s_axis_tready);
        end
      end
      held_valid = m_axis_tvalid && !m_axis_tready && !areset;
      held       = got;
      if (m_axis_tvalid && m_axis_tready) begin
        out_beats++;
        last_out_user = m_axis_tuser;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h required none", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL out_beat: got data=%h keep=%h user=%h id=%0d last=%0b required data=%h keep=%h user=%h id=%0d last=%0b",
                     got.data, got.keep, got.user, got.id, got.last,
                     e.data, e.keep, e.user, e.id, e.last);
          end
        end
      end
      for (int p = 0; p < N; p++) begin
        if (acc_pend[p]) begin
          checks++;
          if (in_pkt && p != cur_port) begin
            errors++;
            $display("FAIL no_interleave: got port %0d required port %0d", p, cur_port);
          end
          if (beat[p] == 0) exp_mask[p] = route_mask_cfg[p*RMW +: RMW];
          sb.push_back('{data: {32'(p), seq[p]}, keep: seq[p][7:0] ^ 8'(p * 17),
                         user: exp_mask[p], id: IDW'(p), last: (beat[p] == len[p] - 1)});
          in_pkt   = (beat[p] != len[p] - 1);
          cur_port = p;
          if (beat[p] == len[p] - 1 && order_n < 64) begin
            order_log[order_n] = p;
            order_n++;
          end
        end
      end
    end
  endtask

  task automatic wait_drain(output bit ok);
    bit busy;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      busy = 1'b0;
      for (int p = 0; p < N; p++) if (req_pkts[p] != done_pkts[p]) busy = 1'b1;
      if (!busy && sb.size() == 0 && !m_axis_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    areset    = 1'b1;
    all_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (s_axis_tready !== '0 || m_axis_tvalid !== 1'b0 || m_axis_tid !== '0 || grant_active !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: got tready=%b tvalid=%b tid=%0d grant=%b required 0000 0 0 0",
                 s_axis_tready, m_axis_tvalid, m_axis_tid, grant_active);
      end
    end
    all_valid = 1'b0;
    tick();
    areset = 1'b0;
    tick();
  endtask

  task automatic test_single_port();
    bit ok;
    int start = out_beats;
    route_mask_cfg[2*RMW +: RMW] = 16'h0004;
    len[2] = 3;
    req_pkts[2]++;
    tick();
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency_bubble: got tvalid=%b required 0", m_axis_tvalid);
    end
    tick();
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tid !== 2'd2 || m_axis_tuser !== 16'h0004) begin
      errors++;
      $display("FAIL single_first_beat: got tvalid=%b tid=%0d tuser=%h required 1 2 0004",
               m_axis_tvalid, m_axis_tid, m_axis_tuser);
    end
    wait_drain(ok);
    checks++;
    if (!ok || out_beats - start != 3) begin
      errors++;
      $display("FAIL single_beats: got drained=%0b beats=%0d required 1 3", ok, out_beats - start);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_order[9] = '{0, 1, 3, 0, 1, 3, 0, 1, 3};
    int start;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
    start = order_n;
    len[0] = 2; len[1] = 2; len[3] = 2;
    req_pkts[0] += 3; req_pkts[1] += 3; req_pkts[3] += 3;
    wait_drain(ok);
    checks++;
    if (!ok || order_n - start != 9) begin
      errors++;
      $display("FAIL rr_packets: got drained=%0b pkts=%0d required 1 9", ok, order_n - start);
    end
    for (int i = 0; i < 9 && start + i < order_n; i++) begin
      checks++;
      if (order_log[start + i] != exp_order[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got port %0d required port %0d", i, order_log[start + i], exp_order[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int start = out_beats;
    int frozen;
    ok = 1'b0;
    len[0] = 6;
    req_pkts[0]++;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_beats - start >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_start: got beats=%0d required >=2", out_beats - start);
    end
    m_axis_tready = 1'b0;
    frozen = out_beats;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (m_axis_tvalid !== 1'b1 || s_axis_tready[0] !== 1'b0 || out_beats != frozen) begin
        errors++;
        $display("FAIL bp_stall: got tvalid=%b tready0=%b beats=%0d required 1 0 %0d",
                 m_axis_tvalid, s_axis_tready[0], out_beats, frozen);
      end
    end
    m_axis_tready = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok || out_beats - start != 6) begin
      errors++;
      $display("FAIL bp_beats: got drained=%0b beats=%0d required 1 6", ok, out_beats - start);
    end
  endtask

  task automatic test_mask_change();
    bit ok;
    ok = 1'b0;
    route_mask_cfg[1*RMW +: RMW] = 16'h00FF;
    len[1] = 4;
    req_pkts[1]++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (beat[1] != 0) begin
        ok = 1'b1;
        break;
      end
    end
    route_mask_cfg[1*RMW +: RMW] = 16'hFF00;
    wait_drain(ok);
    checks++;
    if (!ok || last_out_user !== 16'h00FF) begin
      errors++;
      $display("FAIL mask_old: got drained=%0b tuser=%h required 1 00ff", ok, last_out_user);
    end
    req_pkts[1]++;
    wait_drain(ok);
    checks++;
    if (!ok || last_out_user !== 16'hFF00) begin
      errors++;
      $display("FAIL mask_new: got drained=%0b tuser=%h required 1 ff00", ok, last_out_user);
    end
  endtask

`ifdef PRE_MAC_ARB_PKT_CNT_EN
  task automatic test_pkt_cnt();
    bit ok;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
    len[0] = 1;
    req_pkts[0] += 3;
    wait_drain(ok);
    checks++;
    if (!ok || pkt_cnt[31:0] !== 32'd3 || pkt_cnt[63:32] !== 32'd0) begin
      errors++;
      $display("FAIL pkt_cnt: got drained=%0b cnt0=%h cnt1=%h required 1 3 0",
               ok, pkt_cnt[31:0], pkt_cnt[63:32]);
    end
  endtask
`endif

  initial begin
    areset         = 1'b1;
    all_valid      = 1'b0;
    pause          = '0;
    acc_pend       = '0;
    m_axis_tready  = 1'b1;
    route_mask_cfg = '0;
    last_out_user  = '0;
    for (int p = 0; p < N; p++) begin
      req_pkts[p]  = 0;
      done_pkts[p] = 0;
      len[p]       = 1;
      beat[p]      = 0;
      seq[p]       = 32'(p * 256);
      exp_mask[p]  = '0;
    end
    fork
      source_engine();
      monitor();
    join_none
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_mask_change();
`ifdef PRE_MAC_ARB_PKT_CNT_EN
    test_pkt_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
